// File: rtl/riscv_dmem_sync.sv
// ----------------------------------------------------------------------------
// riscv_dmem_sync
//
// Synchronous single-port data memory for the multi-cycle RISC-V core. The
// core launches its D_MEM bus on the falling edge and this block samples it on
// the rising edge. Read data is therefore registered and stable before the
// core samples it on its next falling edge in the MEM state. The block also
// keeps saturating read and write access counters and a sticky out-of-range
// flag, which testbenches use for statistics.
//
// Parameters
//   ADDR_W     byte address width (word index = ADDR[ADDR_W-1:2])
//   DEPTH      number of 32-bit words; valid word index is 0..DEPTH-1
//   CNT_W      width of the access counters
//
// Ports
//   CLK        clock; all state changes on the rising edge
//   RSTn       asynchronous active-low reset (control and DOUT only)
//   CSN        chip select, active low
//   WEN        write enable, active low (0 = write, 1 = read)
//   BE         byte enables for writes, BE[i] gates byte i
//   ADDR       byte address; the two low bits are ignored
//   DIN        write data
//   DOUT       registered read data, one-edge latency
//   RD_CNT     completed reads, saturating
//   WR_CNT     completed writes (including BE = 0), saturating
//   RANGE_ERR  sticky flag, set by any access with word index >= DEPTH
//   CLR_STATS  synchronous clear of RD_CNT, WR_CNT and RANGE_ERR
// ----------------------------------------------------------------------------
module riscv_dmem_sync #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CSN,
    input  logic              WEN,
    input  logic [3:0]        BE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DIN,
    output logic [31:0]       DOUT,
    output logic [CNT_W-1:0]  RD_CNT,
    output logic [CNT_W-1:0]  WR_CNT,
    output logic              RANGE_ERR,
    input  logic              CLR_STATS
);

    localparam int              IDX_W   = ADDR_W - 2;
    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     DEPTH_U = 32'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end
        return value + 1'b1;
    endfunction

    // ---------------- stage p0: decode of the sampled bus ----------------
    logic [IDX_W-1:0]  word_idx_p0;
    logic [MEM_AW-1:0] mem_idx_p0;
    logic              in_range_p0;
    logic              rd_p0;
    logic              wr_p0;
    logic              err_p0;
    logic [1:0]        unused_addr_lsb;

    assign unused_addr_lsb = ADDR[1:0];
    assign word_idx_p0     = ADDR[ADDR_W-1:2];
    // The range test uses the full word index; the array index may be
    // narrower, so it is only ever used when in_range_p0 is true.
    assign in_range_p0     = (32'(word_idx_p0) < DEPTH_U);
    assign mem_idx_p0      = MEM_AW'(word_idx_p0);
    assign rd_p0           = !CSN && WEN;
    assign wr_p0           = !CSN && !WEN;
    assign err_p0          = !CSN && !in_range_p0;

    // ---------------- stage p1: array, read data and statistics ----------------
    logic [31:0]      mem [DEPTH];
    logic [31:0]      dout_p1;
    logic [CNT_W-1:0] rd_cnt_p1;
    logic [CNT_W-1:0] wr_cnt_p1;
    logic             range_err_p1;

    // The array is never cleared by reset, but an edge that arrives while
    // reset is asserted must not write it, so the array shares the reset
    // sensitivity and simply holds in that branch.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            // array contents are preserved across reset
        end else if (wr_p0 && in_range_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (BE[i]) begin
                    mem[mem_idx_p0][8*i +: 8] <= DIN[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dout_p1      <= '0;
            rd_cnt_p1    <= '0;
            wr_cnt_p1    <= '0;
            range_err_p1 <= 1'b0;
        end else begin
            // Writes leave DOUT alone; out-of-range reads return zero.
            if (rd_p0) begin
                dout_p1 <= in_range_p0 ? mem[mem_idx_p0] : 32'h0000_0000;
            end

            // A clear beats a simultaneous access for the statistics only.
            if (CLR_STATS) begin
                rd_cnt_p1    <= '0;
                wr_cnt_p1    <= '0;
                range_err_p1 <= 1'b0;
            end else begin
                if (rd_p0) begin
                    rd_cnt_p1 <= sat_inc(rd_cnt_p1);
                end
                if (wr_p0) begin
                    wr_cnt_p1 <= sat_inc(wr_cnt_p1);
                end
                if (err_p0) begin
                    range_err_p1 <= 1'b1;
                end
            end
        end
    end

    assign DOUT      = dout_p1;
    assign RD_CNT    = rd_cnt_p1;
    assign WR_CNT    = wr_cnt_p1;
    assign RANGE_ERR = range_err_p1;

endmodule

// File: tb/tb_riscv_dmem_sync.sv
// ----------------------------------------------------------------------------
// tb_riscv_dmem_sync
//
// Self-checking bench for riscv_dmem_sync. Inputs are launched on the falling
// edge like the core does, and outputs are sampled 1 time unit after the
// rising edge. A word-array reference model with plain integer counters
// tracks the expected DOUT, counters, range flag and memory contents.
// ----------------------------------------------------------------------------
module tb_riscv_dmem_sync;

    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 512;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              CSN = 1'b1;
    logic              WEN = 1'b1;
    logic [3:0]        BE = 4'h0;
    logic [ADDR_W-1:0] ADDR = '0;
    logic [31:0]       DIN = '0;
    logic [31:0]       DOUT;
    logic [CNT_W-1:0]  RD_CNT;
    logic [CNT_W-1:0]  WR_CNT;
    logic              RANGE_ERR;
    logic              CLR_STATS = 1'b0;

    riscv_dmem_sync #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .CSN      (CSN),
        .WEN      (WEN),
        .BE       (BE),
        .ADDR     (ADDR),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .RD_CNT   (RD_CNT),
        .WR_CNT   (WR_CNT),
        .RANGE_ERR(RANGE_ERR),
        .CLR_STATS(CLR_STATS)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    logic [31:0] dout_m = '0;
    int          rd_m = 0;
    int          wr_m = 0;
    logic        rerr_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_access(input logic csn, input logic wen, input logic [3:0] be,
                                input logic [ADDR_W-1:0] addr, input logic [31:0] din,
                                input logic clr);
        int idx;
        bit oor;
        idx = int'(addr) / 4;
        oor = (idx >= DEPTH);
        if (!csn) begin
            if (wen) begin
                if (rd_m < CNT_MAX) rd_m++;
                dout_m = oor ? 32'h0 : mem_m[idx];
            end else begin
                if (wr_m < CNT_MAX) wr_m++;
                if (!oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mem_m[idx][8*b +: 8] = din[8*b +: 8];
                    end
                end
            end
            if (oor) rerr_m = 1'b1;
        end
        if (clr) begin
            rd_m   = 0;
            wr_m   = 0;
            rerr_m = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_dout"}, DOUT, dout_m);
        chk({tag, "_rdcnt"}, 32'(RD_CNT), 32'(rd_m));
        chk({tag, "_wrcnt"}, 32'(WR_CNT), 32'(wr_m));
        chk({tag, "_rerr"}, {31'b0, RANGE_ERR}, {31'b0, rerr_m});
    endtask

    task automatic access(input string tag, input logic csn, input logic wen,
                          input logic [3:0] be, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] din, input logic clr);
        @(negedge CLK);
        CSN       = csn;
        WEN       = wen;
        BE        = be;
        ADDR      = addr;
        DIN       = din;
        CLR_STATS = clr;
        @(posedge CLK);
        #1;
        model_access(csn, wen, be, addr, din, clr);
        check_outputs(tag);
    endtask

    task automatic wr(input string tag, input logic [ADDR_W-1:0] addr,
                      input logic [31:0] din, input logic [3:0] be);
        access(tag, 1'b0, 1'b0, be, addr, din, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] addr, input logic clr);
        access(tag, 1'b0, 1'b1, 4'h0, addr, $urandom, clr);
    endtask

    task automatic idle(input string tag, input logic clr);
        access(tag, 1'b1, $urandom_range(0, 1) == 1, 4'($urandom), 12'($urandom), $urandom, clr);
    endtask

    // Hard bound on total run time.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saved;
        logic [ADDR_W-1:0] a;

        // Power-on reset state
        repeat (2) @(negedge CLK);
        check_outputs("por");
        RSTn = 1'b1;

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            wr("init", 12'(i * 4), $urandom, 4'hF);
        end

        // Make every output non-zero before the reset-mid-write test.
        rd("pre_oor", 12'h900, 1'b0);
        rd("pre_rd", 12'h014, 1'b0);
        saved = mem_m[4];

        // Test 1: reset asserted during a write to 0x010
        @(negedge CLK);
        CSN = 1'b0; WEN = 1'b0; BE = 4'hF; ADDR = 12'h010; DIN = ~saved; CLR_STATS = 1'b0;
        #2 RSTn = 1'b0;
        @(posedge CLK);
        #1;
        dout_m = '0; rd_m = 0; wr_m = 0; rerr_m = 1'b0;
        check_outputs("t1_rst");
        @(negedge CLK);
        CSN  = 1'b1;
        RSTn = 1'b1;
        rd("t1_rd", 12'h010, 1'b0);
        chk("t1_mem4", DOUT, saved);
        idle("t1_clr", 1'b1);

        // Test 2: full write then read
        wr("t2_wr", 12'h020, 32'hDEADBEEF, 4'hF);
        rd("t2_rd", 12'h020, 1'b0);
        chk("t2_dout", DOUT, 32'hDEADBEEF);
        chk("t2_rdcnt1", 32'(RD_CNT), 32'd1);
        chk("t2_wrcnt1", 32'(WR_CNT), 32'd1);

        // Test 4: low address bits are ignored
        rd("t4_rd", 12'h023, 1'b0);
        chk("t4_alias", DOUT, 32'hDEADBEEF);

        // Test 3: byte enables
        wr("t3_wr0", 12'h020, 32'h11223344, 4'hF);
        wr("t3_wr1", 12'h020, 32'hAABBCCDD, 4'b0101);
        rd("t3_rd", 12'h020, 1'b0);
        chk("t3_merge", DOUT, 32'h11BB33DD);

        // Idle holds DOUT; a BE=0 write counts, changes nothing, and does not write through
        idle("idle", 1'b0);
        chk("idle_hold", DOUT, 32'h11BB33DD);
        wr("be0_wr", 12'h020, 32'h55555555, 4'h0);
        chk("be0_wrcnt", 32'(WR_CNT), 32'd4);
        chk("be0_nowt", DOUT, 32'h11BB33DD);
        rd("be0_rd", 12'h020, 1'b0);
        chk("be0_data", DOUT, 32'h11BB33DD);

        // Test 5: out-of-range accesses
        rd("t5_oor", 12'h800, 1'b0);
        chk("t5_dout0", DOUT, 32'h0);
        chk("t5_rerr", {31'b0, RANGE_ERR}, 32'd1);
        rd("t5_valid", 12'h024, 1'b0);
        chk("t5_sticky", {31'b0, RANGE_ERR}, 32'd1);
        wr("t5_oor_wr0", 12'h800, 32'hCAFEF00D, 4'hF);
        rd("t5_chk0", 12'h000, 1'b0);
        wr("t5_oor_wr1", 12'hC00, 32'h0BADF00D, 4'hF);
        rd("t5_chk256", 12'h400, 1'b0);
        idle("t5_clr", 1'b1);
        chk("t5_cleared", {31'b0, RANGE_ERR}, 32'd0);

        // Test 6: counter saturation and clear with a simultaneous read
        for (int i = 0; i < 9; i++) begin
            rd("t6_rd", 12'($urandom_range(0, DEPTH * 4 - 1)), 1'b0);
        end
        chk("t6_sat", 32'(RD_CNT), 32'd7);
        rd("t6_clr_rd", 12'h020, 1'b1);
        chk("t6_rdcnt0", 32'(RD_CNT), 32'd0);
        chk("t6_dout", DOUT, 32'h11BB33DD);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) a = 12'($urandom);
            else a = 12'($urandom_range(0, DEPTH * 4 - 1));
            access("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   4'($urandom), a, $urandom, $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
